ex_div_seq: RTL
===============

Name: ex_div_seq

Overview:
- Iterative sequencer for RV32M DIV/DIVU/REM/REMU, beside the single-cycle EX-stage ALU.
- Accepts one divide operation from EX and holds the pipeline through stall_req while a radix-2 restoring iteration runs.
- Presents the result, write address and write enable for exactly one cycle, in the same form the EX stage uses to drive MEM.

Parameters:
XLEN, 32, operand/result width
RADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  EX has a divide-class op this cycle
op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
opv1  in  XLEN  dividend
opv2  in  XLEN  divisor
reg_waddr_i  in  RADDR_W  destination register
annul  in  1  flush from pipeline control; abort the current op
stall_req  out  1  hold IF/ID/EX this cycle
busy  out  1  FSM not in IDLE
done  out  1  result valid this cycle
reg_waddr_o  out  RADDR_W  destination of the completed op
we_o  out  1  register write enable (equals done)
result  out  XLEN  quotient or remainder

Behaviour:
- Reset: rst sampled high returns the FSM to IDLE on that edge, from any state. All registered outputs clear to 0: done, we_o, result, reg_waddr_o, busy, and the counter. stall_req is 0 while rst is high.
- States: IDLE, ITER, SIGN, DONE.
- IDLE, start=1:
  - Latch op, reg_waddr_i, sign flags, |opv1| and |opv2|. Magnitudes are taken only for DIV/REM; DIVU/REMU use the raw values.
  - Clear the remainder accumulator and set the counter to 0.
  - Next state is ITER, unless a special case applies.
- Special cases, decided in IDLE, go straight to DONE with the result below:
  - Divisor 0: quotient = all ones; remainder = opv1.
  - Signed overflow (DIV/REM, opv1=0x80000000, opv2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- ITER, one step per cycle:
  - Shift {rem, quo} left by 1, bringing in the quotient MSB.
  - If rem >= divisor: rem -= divisor and set quo[0].
  - After XLEN steps (counter == XLEN-1) go to SIGN.
- SIGN, one cycle:
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend (signed ops only).
  - Select quotient or remainder per op, register it into result, then go to DONE.
- DONE, one cycle: done=1, we_o=1, reg_waddr_o = latched address, then return to IDLE. result holds its value until the next DONE.
- Latency, with start sampled at cycle T:
  - Normal op: done at T+XLEN+2 (T+34 for XLEN=32).
  - Special case: done at T+1.
- stall_req (combinational) = (IDLE & start & ~annul) | ITER | SIGN.
  - Low in DONE, so the pipeline advances while the result is presented.
  - Back-to-back divides are therefore allowed: start may rise in the cycle after DONE.
- annul (synchronous), in ITER, SIGN or DONE, or together with start in IDLE:
  - FSM goes to IDLE on the next edge; no done or we_o for that op.
  - If annul coincides with DONE, done for that cycle is still 0.
- start while not IDLE: ignored and not queued.
- Counter is log2(XLEN)+1 bits wide and never wraps within an op.
- busy = state != IDLE.

Decomposition:
- defines.v gets the op encodings EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP and EXE_REMU_OP, plus alusel EXE_RES_DIV, so the decoder and EX share them.
- State encoding stays local.
- One sub-module is natural: div_step, a combinational single restoring step (rem_in, quo_in, divisor -> rem_out, quo_out). The FSM instantiates it once per cycle.

Test Plan:
- DIVU 100/7, start at T -> stall_req high T..T+33; done=1, we_o=1, result=14 at T+34; reg_waddr_o = given address.
- REM -7 % 2 -> result 0xFFFFFFFF (-1); DIV -7/2 -> result 0xFFFFFFFD (-3).
- DIVU 5/0 -> done at T+1 with result 0xFFFFFFFF; REMU 5/0 -> result 5; stall_req high only at T.
- DIV 0x80000000/0xFFFFFFFF -> done at T+1, result 0x80000000; REM of the same operands -> result 0.
- annul asserted in ITER cycle 10 -> busy=0 the next cycle; no done; a new start the following cycle completes correctly. Repeat with annul coincident with DONE -> done stays 0.
- start pulsed during ITER -> ignored, first result unaffected; rst asserted mid-ITER -> all outputs 0 the next cycle, FSM in IDLE.

Source files
------------

// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the RV32M divide sequencer: op encodings and ALU result select
// used by the decoder and the EX stage.
package ex_div_seq_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    localparam logic [1:0] EXE_DIV_OP  = 2'b00;
    localparam logic [1:0] EXE_DIVU_OP = 2'b01;
    localparam logic [1:0] EXE_REM_OP  = 2'b10;
    localparam logic [1:0] EXE_REMU_OP = 2'b11;

    localparam logic [2:0] EXE_RES_DIV = 3'b110;

    function automatic logic is_signed_op(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_div_seq_if.sv
// EX-side connection of the divide sequencer: request, annul, stall and the
// writeback triple that feeds MEM.
interface ex_div_seq_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [XLEN-1:0]    opv1;
    logic [XLEN-1:0]    opv2;
    logic [RADDR_W-1:0] reg_waddr_i;
    logic               annul;
    logic               stall_req;
    logic               busy;
    logic               done;
    logic [RADDR_W-1:0] reg_waddr_o;
    logic               we_o;
    logic [XLEN-1:0]    result;

    modport master (
        output start, op, opv1, opv2, reg_waddr_i, annul,
        input  stall_req, busy, done, reg_waddr_o, we_o, result
    );

    modport slave (
        input  start, op, opv1, opv2, reg_waddr_i, annul,
        output stall_req, busy, done, reg_waddr_o, we_o, result
    );
endinterface

// File: rtl/ex_div_seq_div_step.sv
// One radix-2 restoring division step on the {rem, quo} pair.
module ex_div_seq_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    // One extra bit so the shifted-out remainder MSB is not lost before the compare.
    logic [XLEN:0] rem_sh;

    always_comb begin
        rem_sh  = {rem_in, quo_in[XLEN-1]};
        quo_out = {quo_in[XLEN-2:0], 1'b0};
        rem_out = rem_sh[XLEN-1:0];
        if (rem_sh >= {1'b0, divisor}) begin
            rem_out    = XLEN'(rem_sh - {1'b0, divisor});
            quo_out[0] = 1'b1;
        end
    end
endmodule

// File: rtl/ex_div_seq.sv
// Iterative DIV/DIVU/REM/REMU sequencer beside the EX ALU; stalls the front of the
// pipeline while iterating and presents a one-cycle writeback.
module ex_div_seq
    import ex_div_seq_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    ex_div_seq_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [XLEN-1:0]    rem_reg, quo_reg, divisor_reg, result_reg;
    logic               rem_sel_reg, neg_q_reg, neg_r_reg, done_reg;
    logic [RADDR_W-1:0] waddr_reg, waddr_o_reg;

    logic               sgn, s1, s2, div_zero, ovf;
    logic [XLEN-1:0]    mag1, mag2, special_res, q_final, r_final;
    logic [XLEN-1:0]    step_rem, step_quo;

    always_comb begin
        sgn      = is_signed_op(bus.op);
        s1       = sgn & bus.opv1[XLEN-1];
        s2       = sgn & bus.opv2[XLEN-1];
        mag1     = s1 ? -bus.opv1 : bus.opv1;
        mag2     = s2 ? -bus.opv2 : bus.opv2;
        div_zero = (bus.opv2 == '0);
        ovf      = sgn && (bus.opv1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.opv2 == '1);
        // Divide-by-zero takes priority; the overflow case only exists for a nonzero divisor.
        if (div_zero)
            special_res = is_rem_op(bus.op) ? bus.opv1 : '1;
        else
            special_res = is_rem_op(bus.op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        q_final  = neg_q_reg ? -quo_reg : quo_reg;
        r_final  = neg_r_reg ? -rem_reg : rem_reg;
    end

    ex_div_seq_div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
            rem_sel_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            done_reg    <= 1'b0;
            waddr_reg   <= '0;
            waddr_o_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.annul) begin
                        rem_sel_reg <= is_rem_op(bus.op);
                        neg_q_reg   <= s1 ^ s2;
                        neg_r_reg   <= s1;
                        waddr_reg   <= bus.reg_waddr_i;
                        quo_reg     <= mag1;
                        divisor_reg <= mag2;
                        rem_reg     <= '0;
                        cnt_reg     <= '0;
                        if (div_zero || ovf) begin
                            result_reg  <= special_res;
                            waddr_o_reg <= bus.reg_waddr_i;
                            done_reg    <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            state_reg <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (bus.annul) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= step_rem;
                        quo_reg <= step_quo;
                        if (cnt_reg == CNT_W'(XLEN-1))
                            state_reg <= SIGN;
                        else
                            cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                SIGN: begin
                    if (bus.annul) begin
                        state_reg <= IDLE;
                    end else begin
                        result_reg  <= rem_sel_reg ? r_final : q_final;
                        waddr_o_reg <= waddr_reg;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A flush landing on the DONE cycle must still suppress the writeback.
    assign bus.done        = done_reg & ~bus.annul;
    assign bus.we_o        = done_reg & ~bus.annul;
    assign bus.result      = result_reg;
    assign bus.reg_waddr_o = waddr_o_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.stall_req   = ~rst & (((state_reg == IDLE) & bus.start & ~bus.annul) |
                                     (state_reg == ITER) | (state_reg == SIGN));
endmodule
